hdmi_phase_tuner: RTL and testbench
===================================

HDMI_PHASE_TUNER -- requirements
Module: hdmi_phase_tuner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 64: cycles discarded after any configuration change.
REQ-002 SHALL have parameter WINDOW_BITS, default 16: measurement window of 2^WINDOW_BITS cycles per candidate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 18: TRACK loses sync after 2^TIMEOUT_BITS cycles without a control token.
REQ-004 SHALL have parameter MIN_HITS, default 256: minimum best-candidate token count accepted as a lock.
REQ-005 clk  input  1  recovered TMDS pixel clock; the only clock.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 pll_locked  input  1  bit-clock PLL lock; treated as level, already in clk domain.
REQ-008 d0  input  10  raw channel-0 TMDS word from the clock-crossing stage.
REQ-009 pll_delay  output  4  PLL fine-delay setting driven to the PLL.
REQ-010 phase  output  4  word-alignment phase, range 0..9, driven to the clock crosser.
REQ-011 valid  output  1  high only in TRACK.
REQ-012 state  output  3  current FSM state for debug and LEDs.
REQ-013 best_hits  output  WINDOW_BITS+1  token count of the configuration currently applied.

Function
REQ-014 A hit SHALL be d0 equal to any of 354, 0AB, 154, 2AB hex; hit is registered, so counting lags d0 by 1 cycle.
REQ-015 FSM states SHALL be IDLE=0, SETTLE=1, MEASURE=2, APPLY=3, TRACK=4.
REQ-016 IDLE: pll_delay=0, phase=0, valid=0; when pll_locked=1, clear best record and go to SETTLE.
REQ-017 SETTLE: count SETTLE_CYCLES cycles, ignoring hits, then go to MEASURE with the hit counter zeroed.
REQ-018 MEASURE: count hits for exactly 2^WINDOW_BITS cycles; the counter has WINDOW_BITS+1 bits and cannot wrap.
REQ-019 At window end, if count > best (strictly), SHALL store count, pll_delay and phase as best; ties keep the earlier candidate.
REQ-020 Candidate order SHALL be phase 0..9 inner loop and pll_delay 0..15 outer loop: 160 candidates, then APPLY.
REQ-021 After a window the next candidate SHALL be driven in the same cycle the state enters SETTLE.
REQ-022 APPLY (1 cycle): if best >= MIN_HITS, drive the best pll_delay/phase and go to SETTLE-then-TRACK; otherwise restart the sweep from candidate (0,0) with best cleared.
REQ-023 TRACK: valid=1; a hit reloads the timeout counter; timeout expiry sets valid=0 and starts a full sweep from (0,0).
REQ-024 pll_locked=0 in any state SHALL force IDLE next cycle, with valid=0 that cycle and outputs zeroed per REQ-016.
REQ-025 The post-APPLY SETTLE SHALL NOT measure; it enters TRACK with the timeout counter cleared.

Reset
REQ-026 On reset=0 at a clk edge: state=IDLE, pll_delay=0, phase=0, valid=0, best_hits=0; all counters and the best record cleared.
REQ-027 Reset SHALL override pll_locked and take effect mid-sweep or mid-track identically.

Structure
REQ-028 The four control-token constants, state encoding and phase limit 9 SHALL live in shared package hdmi_pkg.
REQ-029 Token matching SHALL be one sub-module tmds_ctrl_detect (10-bit in, registered 1-bit hit out); the rest is one FSM plus counters.

Verification
(Bench parameters: SETTLE_CYCLES=4, WINDOW_BITS=4, TIMEOUT_BITS=5, MIN_HITS=8.)
REQ-030 Case 1: pll_locked=1 and d0=2AB only while candidate (3,7) is driven -> best is (3,7) with best_hits=16 -> TRACK, valid=1.
REQ-031 Case 2: equal hits at (0,2) and (5,2) -> best is (0,2).
REQ-032 Case 3: hits never exceed 7 -> APPLY restarts the sweep at (0,0) and valid stays 0.
REQ-033 Case 4: in TRACK, d0 held at 0 for 32 cycles -> valid falls and the sweep restarts at (0,0).
REQ-034 Case 5: pll_locked dropped mid-MEASURE -> next cycle IDLE with all outputs 0; relock -> sweep restarts at (0,0).
REQ-035 Case 6: reset=0 asserted in TRACK for 1 cycle -> all outputs 0 at the next edge, FSM in IDLE.

Source files
------------

// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared definitions for the HDMI phase tuner: the four TMDS
//               control-token code words, the tuner state encoding, the
//               candidate sweep limits and a token-match helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

  // TMDS control-period code words (C1C0 = 00, 01, 10, 11)
  localparam logic [9:0] CTRL_TOKEN_0 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_1 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_2 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_3 = 10'h2AB;

  // Word-alignment phase runs 0..9; PLL fine delay runs 0..15
  localparam logic [3:0] PHASE_MAX = 4'd9;
  localparam logic [3:0] DELAY_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_APPLY   = 3'd3,
    ST_TRACK   = 3'd4
  } tuner_state_t;

  function automatic logic is_ctrl_token(input logic [9:0] word);
    return (word == CTRL_TOKEN_0) || (word == CTRL_TOKEN_1) ||
           (word == CTRL_TOKEN_2) || (word == CTRL_TOKEN_3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_ctrl_detect.sv
`default_nettype none
// ============================================================================
// Module      : tmds_ctrl_detect
// Description : Flags a raw 10-bit TMDS word that matches any of the four
//               control tokens. The flag is registered, so it lags the word
//               by one clock.
// Ports       : clk   - pixel clock
//               reset - synchronous, active-low reset
//               d     - raw 10-bit TMDS word
//               hit   - registered match flag
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_ctrl_detect
  import hdmi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] d,
  output logic       hit
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit <= 1'b0;
    end else begin
      hit <= is_ctrl_token(d);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdmi_phase_tuner.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_phase_tuner
// Description : Sweeps all 160 (pll_delay, phase) candidates, counts TMDS
//               control tokens on channel 0 for a fixed window per candidate,
//               applies the best one and tracks it until tokens disappear.
// Ports       : clk        - recovered TMDS pixel clock
//               reset      - synchronous, active-low reset
//               pll_locked - bit-clock PLL lock level
//               d0         - raw channel-0 TMDS word
//               pll_delay  - PLL fine-delay setting
//               phase      - word-alignment phase (0..9)
//               valid      - high while tracking a locked configuration
//               state      - FSM state for debug
//               best_hits  - token count of the best/applied configuration
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_phase_tuner
  import hdmi_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int WINDOW_BITS   = 16,
  parameter int TIMEOUT_BITS  = 18,
  parameter int MIN_HITS      = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic [9:0]             d0,
  output logic [3:0]             pll_delay,
  output logic [3:0]             phase,
  output logic                   valid,
  output logic [2:0]             state,
  output logic [WINDOW_BITS:0]   best_hits
);

  localparam int CW = WINDOW_BITS + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] MIN_HITS_W  = CW'(MIN_HITS);

  tuner_state_t            st;
  logic                    hit;
  logic [SW-1:0]           settle_cnt;
  logic [WINDOW_BITS-1:0]  win_cnt;
  logic [CW-1:0]           hit_count;
  logic [TIMEOUT_BITS-1:0] timeout_cnt;
  logic [3:0]              best_delay;
  logic [3:0]              best_phase;
  // Set by APPLY so the following SETTLE hands over to TRACK, not MEASURE
  logic                    to_track;

  logic [CW-1:0]           window_total;
  logic                    last_candidate;

  tmds_ctrl_detect u_detect (
    .clk   (clk),
    .reset (reset),
    .d     (d0),
    .hit   (hit)
  );

  // Count including the hit sampled this cycle; at most 2^WINDOW_BITS
  assign window_total   = hit_count + CW'(hit);
  assign last_candidate = (pll_delay == DELAY_MAX) && (phase == PHASE_MAX);
  assign state          = st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st          <= ST_IDLE;
      pll_delay   <= 4'd0;
      phase       <= 4'd0;
      valid       <= 1'b0;
      best_hits   <= '0;
      best_delay  <= 4'd0;
      best_phase  <= 4'd0;
      settle_cnt  <= '0;
      win_cnt     <= '0;
      hit_count   <= '0;
      timeout_cnt <= '0;
      to_track    <= 1'b0;
    end else if (!pll_locked) begin
      // Losing the bit clock abandons whatever was in progress
      st          <= ST_IDLE;
      pll_delay   <= 4'd0;
      phase       <= 4'd0;
      valid       <= 1'b0;
      best_hits   <= '0;
      best_delay  <= 4'd0;
      best_phase  <= 4'd0;
      settle_cnt  <= '0;
      win_cnt     <= '0;
      hit_count   <= '0;
      timeout_cnt <= '0;
      to_track    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          pll_delay  <= 4'd0;
          phase      <= 4'd0;
          valid      <= 1'b0;
          best_hits  <= '0;
          best_delay <= 4'd0;
          best_phase <= 4'd0;
          settle_cnt <= '0;
          to_track   <= 1'b0;
          st         <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            if (to_track) begin
              to_track    <= 1'b0;
              timeout_cnt <= '0;
              valid       <= 1'b1;
              st          <= ST_TRACK;
            end else begin
              hit_count <= '0;
              win_cnt   <= '0;
              st        <= ST_MEASURE;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        ST_MEASURE: begin
          if (win_cnt == '1) begin
            // Strictly greater: on a tie the earlier candidate is kept
            if (window_total > best_hits) begin
              best_hits  <= window_total;
              best_delay <= pll_delay;
              best_phase <= phase;
            end
            if (last_candidate) begin
              st <= ST_APPLY;
            end else begin
              if (phase == PHASE_MAX) begin
                phase     <= 4'd0;
                pll_delay <= pll_delay + 4'd1;
              end else begin
                phase <= phase + 4'd1;
              end
              settle_cnt <= '0;
              st         <= ST_SETTLE;
            end
          end else begin
            hit_count <= window_total;
            win_cnt   <= win_cnt + WINDOW_BITS'(1);
          end
        end

        ST_APPLY: begin
          if (best_hits >= MIN_HITS_W) begin
            pll_delay <= best_delay;
            phase     <= best_phase;
            to_track  <= 1'b1;
          end else begin
            pll_delay  <= 4'd0;
            phase      <= 4'd0;
            best_hits  <= '0;
            best_delay <= 4'd0;
            best_phase <= 4'd0;
            to_track   <= 1'b0;
          end
          settle_cnt <= '0;
          st         <= ST_SETTLE;
        end

        ST_TRACK: begin
          if (hit) begin
            timeout_cnt <= '0;
          end else if (timeout_cnt == '1) begin
            // No token for 2^TIMEOUT_BITS cycles: full re-sweep from (0,0)
            valid       <= 1'b0;
            pll_delay   <= 4'd0;
            phase       <= 4'd0;
            best_hits   <= '0;
            best_delay  <= 4'd0;
            best_phase  <= 4'd0;
            timeout_cnt <= '0;
            settle_cnt  <= '0;
            to_track    <= 1'b0;
            st          <= ST_SETTLE;
          end else begin
            timeout_cnt <= timeout_cnt + TIMEOUT_BITS'(1);
          end
        end

        default: begin
          valid <= 1'b0;
          st    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_phase_tuner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_phase_tuner
// Description : Directed self-checking bench for hdmi_phase_tuner with
//               SETTLE_CYCLES=4, WINDOW_BITS=4, TIMEOUT_BITS=5, MIN_HITS=8.
//               The channel-0 word is generated from a per-case pattern
//               applied to the candidate currently driven.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_phase_tuner;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_APPLY   = 3'd3;
  localparam logic [2:0] S_TRACK   = 3'd4;
  localparam int SWEEP_BUDGET = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic [9:0] d0;
  logic [3:0] pll_delay;
  logic [3:0] phase;
  logic       valid;
  logic [2:0] state;
  logic [4:0] best_hits;

  int n_checks = 0;
  int n_errors = 0;
  int mode     = 0;  // 0: silent, 1: token at (3,7), 2: tokens at (0,2)/(5,2), 3: token every 3rd cycle
  int cyc      = 0;

  hdmi_phase_tuner #(
    .SETTLE_CYCLES (4),
    .WINDOW_BITS   (4),
    .TIMEOUT_BITS  (5),
    .MIN_HITS      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .d0         (d0),
    .pll_delay  (pll_delay),
    .phase      (phase),
    .valid      (valid),
    .state      (state),
    .best_hits  (best_hits)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] gen_d0();
    case (mode)
      1: return (pll_delay == 4'd3 && phase == 4'd7) ? 10'h2AB : 10'h000;
      2: return ((pll_delay == 4'd0 || pll_delay == 4'd5) && phase == 4'd2) ? 10'h2AB : 10'h000;
      3: return (cyc % 3 == 0) ? 10'h2AB : 10'h000;
      default: return 10'h000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    d0 = gen_d0();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    pll_locked = 1'b0;
    d0         = 10'h000;
    repeat (3) tick();

    // Reset state
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_delay", 32'(pll_delay), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_best", 32'(best_hits), 32'd0);

    reset = 1'b1;
    tick();
    chk("idle_unlocked", 32'(state), 32'(S_IDLE));

    // Case 1: tokens only at candidate (3,7)
    mode       = 1;
    pll_locked = 1'b1;
    tick();
    chk("c1_settle", 32'(state), 32'(S_SETTLE));
    chk("c1_first_cand", 32'({pll_delay, phase}), 32'h00);
    wait_state(S_APPLY, SWEEP_BUDGET, "c1_reach_apply");
    chk("c1_apply_best", 32'(best_hits), 32'd16);
    chk("c1_apply_valid", 32'(valid), 32'd0);
    wait_state(S_TRACK, 20, "c1_reach_track");
    chk("c1_delay", 32'(pll_delay), 32'd3);
    chk("c1_phase", 32'(phase), 32'd7);
    chk("c1_valid", 32'(valid), 32'd1);
    chk("c1_best", 32'(best_hits), 32'd16);

    // Case 6: one-cycle reset while tracking
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("c6_state", 32'(state), 32'(S_IDLE));
    chk("c6_delay", 32'(pll_delay), 32'd0);
    chk("c6_phase", 32'(phase), 32'd0);
    chk("c6_valid", 32'(valid), 32'd0);
    chk("c6_best", 32'(best_hits), 32'd0);

    // Case 2: equal hits at (0,2) and (5,2), earlier must win
    reset = 1'b1;
    mode  = 2;
    d0    = gen_d0();
    wait_state(S_APPLY, SWEEP_BUDGET, "c2_reach_apply");
    chk("c2_apply_best", 32'(best_hits), 32'd16);
    wait_state(S_TRACK, 20, "c2_reach_track");
    chk("c2_delay", 32'(pll_delay), 32'd0);
    chk("c2_phase", 32'(phase), 32'd2);
    chk("c2_valid", 32'(valid), 32'd1);

    // Case 4: silence in TRACK times out after 2^5 token-free cycles
    repeat (3) tick();
    mode = 0;
    d0   = 10'h000;
    repeat (32) tick();
    chk("c4_valid_hold", 32'(valid), 32'd1);
    chk("c4_state_hold", 32'(state), 32'(S_TRACK));
    mode = 3;
    tick();
    chk("c4_valid_fall", 32'(valid), 32'd0);
    chk("c4_state", 32'(state), 32'(S_SETTLE));
    chk("c4_cand", 32'({pll_delay, phase}), 32'h00);
    chk("c4_best", 32'(best_hits), 32'd0);

    // Case 3: at most 6 hits per window, below MIN_HITS
    wait_state(S_APPLY, SWEEP_BUDGET, "c3_reach_apply");
    chk("c3_apply_best", 32'(best_hits), 32'd6);
    tick();
    chk("c3_restart_state", 32'(state), 32'(S_SETTLE));
    chk("c3_restart_cand", 32'({pll_delay, phase}), 32'h00);
    chk("c3_restart_best", 32'(best_hits), 32'd0);
    chk("c3_valid", 32'(valid), 32'd0);

    // Case 5: lock loss in the middle of a measurement window
    repeat (60) tick();
    wait_state(S_MEASURE, 30, "c5_reach_measure");
    repeat (3) tick();
    chk("c5_best_before", 32'(best_hits >= 5'd5), 32'd1);
    pll_locked = 1'b0;
    tick();
    chk("c5_state", 32'(state), 32'(S_IDLE));
    chk("c5_delay", 32'(pll_delay), 32'd0);
    chk("c5_phase", 32'(phase), 32'd0);
    chk("c5_valid", 32'(valid), 32'd0);
    chk("c5_best", 32'(best_hits), 32'd0);
    pll_locked = 1'b1;
    tick();
    chk("c5_relock_state", 32'(state), 32'(S_SETTLE));
    chk("c5_relock_cand", 32'({pll_delay, phase}), 32'h00);
    repeat (4) tick();
    chk("c5_relock_measure", 32'(state), 32'(S_MEASURE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
